// File: rtl/iter_alu.sv
// Iterative integer ALU: single-cycle base ops plus WIDTH-cycle shift-add multiply
// and restoring divide, with a valid/ready handshake on both sides.
module iter_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] lhs_i,
    input  logic [WIDTH-1:0] rhs_i,
    input  logic [4:0]       function_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic [1:0]       dbg_state_o
);

    // Handshake: an input transfer happens on a rising edge with in_valid_i && in_ready_o;
    // an output transfer happens on a rising edge with out_valid_o && out_ready_i.
    localparam int SHAMT_W = $clog2(WIDTH);
    localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state_q;
    logic                 out_valid_q;
    logic [WIDTH-1:0]     result_q;
    logic [SHAMT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0]   prod_q;
    logic [WIDTH-1:0]     opnd_q;
    logic [1:0]           op_q;
    logic                 neg_q;
    logic                 zero_q;

    logic [SHAMT_W-1:0]   shamt;
    logic signed [WIDTH-1:0] lhs_s;
    logic [WIDTH-1:0]     base_d;
    logic                 is_div;
    logic                 a_signed;
    logic                 b_signed;
    logic                 a_neg;
    logic                 b_neg;
    logic                 neg_d;
    logic [WIDTH-1:0]     a_mag_d;
    logic [WIDTH-1:0]     b_mag_d;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_d;
    logic [2*WIDTH-1:0]   mul_signed;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_trial;
    logic [2*WIDTH-1:0]   div_d;
    logic [WIDTH-1:0]     div_sel;
    logic [2*WIDTH-1:0]   step_d;
    logic [WIDTH-1:0]     mul_res_d;
    logic [WIDTH-1:0]     div_res_d;

    assign in_ready_o  = (state_q == S_IDLE) && !rst_i;
    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;
    assign dbg_state_o = state_q;

    always_comb begin
        shamt = rhs_i[SHAMT_W-1:0];
        lhs_s = lhs_i;
        base_d = '0;
        case (function_i)
            5'b00000: base_d = lhs_i + rhs_i;
            5'b01000: base_d = lhs_i - rhs_i;
            5'b00001: base_d = lhs_i << shamt;
            5'b00010: base_d = {{(WIDTH-1){1'b0}}, ($signed(lhs_i) < $signed(rhs_i))};
            5'b00011: base_d = {{(WIDTH-1){1'b0}}, (lhs_i < rhs_i)};
            5'b00100: base_d = lhs_i ^ rhs_i;
            5'b00101: base_d = lhs_i >> shamt;
            5'b01101: base_d = lhs_s >>> shamt;
            5'b00110: base_d = lhs_i | rhs_i;
            5'b00111: base_d = lhs_i & rhs_i;
            default:  base_d = '0;
        endcase
    end

    // Both iterations work on magnitudes; the sign is reapplied on the final step.
    always_comb begin
        is_div   = function_i[2];
        a_signed = is_div ? !function_i[0] : (function_i[1] ^ function_i[0]);
        b_signed = is_div ? !function_i[0] : (function_i[1:0] == 2'b01);
        a_neg    = a_signed && lhs_i[WIDTH-1];
        b_neg    = b_signed && rhs_i[WIDTH-1];
        a_mag_d  = a_neg ? (-lhs_i) : lhs_i;
        b_mag_d  = b_neg ? (-rhs_i) : rhs_i;
        neg_d    = (is_div && function_i[1]) ? a_neg : (a_neg ^ b_neg);
    end

    always_comb begin
        mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                  + ({(WIDTH+1){prod_q[0]}} & {1'b0, opnd_q});
        mul_d     = {mul_sum, prod_q[WIDTH-1:1]};
        div_shift = prod_q[2*WIDTH-1:WIDTH-1];
        div_trial = div_shift - {1'b0, opnd_q};
        if (!div_trial[WIDTH]) begin
            div_d = {div_trial[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
        end else begin
            div_d = {div_shift[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
        end
        step_d = (state_q == S_MUL) ? mul_d : div_d;

        mul_signed = neg_q ? (-mul_d) : mul_d;
        mul_res_d  = (op_q == 2'b00) ? mul_signed[WIDTH-1:0] : mul_signed[2*WIDTH-1:WIDTH];

        // A zero divisor leaves the dividend in the remainder, so REM/REMU fall out
        // naturally; only the quotient needs forcing to all ones.
        div_sel = op_q[1] ? div_d[2*WIDTH-1:WIDTH] : div_d[WIDTH-1:0];
        if (zero_q && !op_q[1]) begin
            div_res_d = '1;
        end else begin
            div_res_d = neg_q ? (-div_sel) : div_sel;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            cnt_q       <= '0;
            prod_q      <= '0;
            opnd_q      <= '0;
            op_q        <= '0;
            neg_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid_i) begin
                        if (!function_i[4]) begin
                            result_q    <= base_d;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            prod_q  <= {{WIDTH{1'b0}}, a_mag_d};
                            opnd_q  <= b_mag_d;
                            op_q    <= function_i[1:0];
                            neg_q   <= neg_d;
                            zero_q  <= (rhs_i == '0);
                            cnt_q   <= '0;
                            state_q <= is_div ? S_DIV : S_MUL;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    prod_q <= step_d;
                    if (cnt_q == CNT_LAST) begin
                        cnt_q       <= '0;
                        result_q    <= (state_q == S_MUL) ? mul_res_d : div_res_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + SHAMT_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_alu.sv
// Directed-vector bench for iter_alu: driver pushes expected results, a negedge
// monitor pops and compares on every output transfer.
module tb_iter_alu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] lhs;
    logic [W-1:0] rhs;
    logic [4:0]   func;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [1:0]   dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    logic [W-1:0] mon_exp;
    string        mon_name;

    iter_alu #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .lhs_i       (lhs),
        .rhs_i       (rhs),
        .function_i  (func),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%h required=0x%h", nm, act, exp);
        end
    endtask

    // Monitor: compare on every cycle that will complete an output transfer.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result actual=0x%h required=none", result);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_name = name_q.pop_front();
                check(mon_name, result, mon_exp);
            end
        end
    end

    // Called at a negedge with out_ready=1; returns at a negedge with the DUT idle.
    task automatic do_op(input string nm, input logic [4:0] f, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] e, input int lat);
        int k;
        bit seen;
        k = 0;
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        exp_q.push_back(e);
        name_q.push_back(nm);
        func = f;
        lhs = a;
        rhs = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lhs  = $urandom;
        rhs  = $urandom;
        func = 5'($urandom_range(0, 31));
        k = 0;
        seen = 1'b0;
        while (!seen && k < 100) begin
            @(negedge clk);
            k++;
            if (out_valid) seen = 1'b1;
        end
        check({nm, "_latency"}, W'(k), W'(lat));
        check({nm, "_inready_busy"}, W'(in_ready), W'(0));
        @(negedge clk);
        check({nm, "_valid_drop"}, W'(out_valid), W'(0));
        check({nm, "_inready_back"}, W'(in_ready), W'(1));
    endtask

    initial begin
        int k;
        bit seen;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        lhs = '0;
        rhs = '0;
        func = '0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_result", result, W'(0));
        check("rst_in_ready", W'(in_ready), W'(0));
        check("rst_state", W'(dbg_state), W'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", W'(in_ready), W'(1));

        do_op("add",     5'b00000, 32'd5,        32'd7,        32'd12,       1);
        do_op("sub",     5'b01000, 32'd5,        32'd7,        32'hFFFFFFFE, 1);
        do_op("sra",     5'b01101, 32'h80000000, 32'd4,        32'hF8000000, 1);
        do_op("slt",     5'b00010, 32'hFFFFFFFF, 32'd1,        32'd1,        1);
        do_op("sltu",    5'b00011, 32'hFFFFFFFF, 32'd1,        32'd0,        1);
        do_op("sll",     5'b00001, 32'd1,        32'h21,       32'd2,        1);
        do_op("srl",     5'b00101, 32'h80000000, 32'h3F,       32'd1,        1);
        do_op("xor",     5'b00100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1);
        do_op("or",      5'b00110, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1);
        do_op("and",     5'b00111, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1);
        do_op("rsvd",    5'b01001, 32'd5,        32'd7,        32'd0,        1);
        do_op("mul",     5'b10000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        33);
        do_op("mul_b3",  5'b11000, 32'd3,        32'd4,        32'd12,       33);
        do_op("mulh",    5'b10001, 32'h80000000, 32'h80000000, 32'h40000000, 33);
        do_op("mulhu",   5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        do_op("mulhsu",  5'b10010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33);
        do_op("div_z",   5'b10100, 32'd7,        32'd0,        32'hFFFFFFFF, 33);
        do_op("divu_z",  5'b10101, 32'd7,        32'd0,        32'hFFFFFFFF, 33);
        do_op("remu_z",  5'b10111, 32'd7,        32'd0,        32'd7,        33);
        do_op("rem_z",   5'b10110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 33);
        do_op("div_ovf", 5'b10100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);
        do_op("rem_ovf", 5'b10110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        33);
        do_op("div_neg", 5'b10100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
        do_op("rem_neg", 5'b10110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
        do_op("div_nd",  5'b10100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33);
        do_op("rem_nd",  5'b10110, 32'd7,        32'hFFFFFFFE, 32'd1,        33);
        do_op("divu",    5'b10101, 32'd100,      32'd7,        32'd14,       33);

        // Back-pressure: hold the result for 10 cycles and poke in_valid meanwhile.
        out_ready = 1'b0;
        exp_q.push_back(32'd3);
        name_q.push_back("stall_add");
        func = 5'b00000;
        lhs = 32'd1;
        rhs = 32'd2;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 100) begin
            @(negedge clk);
            k++;
            if (out_valid) seen = 1'b1;
        end
        check("stall_latency", W'(k), W'(1));
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                func = 5'b00000;
                lhs = 32'd100;
                rhs = 32'd100;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            check("stall_valid", W'(out_valid), W'(1));
            check("stall_result", result, W'(3));
            check("stall_inready", W'(in_ready), W'(0));
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("stall_release_valid", W'(out_valid), W'(0));
        check("stall_release_ready", W'(in_ready), W'(1));
        check("stall_result_hold", result, W'(3));
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("stall_pulse_ignored", W'(seen), W'(0));

        // Reset in the middle of a divide.
        func = 5'b10101;
        lhs = 32'd100;
        rhs = 32'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        func = 5'b00000;
        lhs = 32'd1;
        rhs = 32'd1;
        in_valid = 1'b1;
        #1 check("midrst_inready", W'(in_ready), W'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("midrst_valid", W'(out_valid), W'(0));
        check("midrst_result", result, W'(0));
        check("midrst_ready", W'(in_ready), W'(1));
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_stale", W'(seen), W'(0));

        do_op("remu_after_rst", 5'b10111, 32'd100, 32'd7, 32'd2, 33);

        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_results actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/iter_alu.md
ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; legal values are powers of two from 8 to 64.
REQ-002 Parameter SHAMT_W, default $clog2(WIDTH), shift-amount width; derived only, never overridden.
REQ-003 Clock  input  1  rising-edge clock for all state.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 InValid  input  1  the operands and Function are valid this cycle.
REQ-006 InReady  output  1  the block can accept an operation this cycle.
REQ-007 LHS  input  WIDTH  first operand.
REQ-008 RHS  input  WIDTH  second operand.
REQ-009 Function  input  5  operation select, encoded per REQ-013.
REQ-010 OutValid  output  1  Result holds a completed operation.
REQ-011 OutReady  input  1  the consumer takes Result this cycle.
REQ-012 Result  output  WIDTH  registered operation result.

Function
REQ-013 Function encoding SHALL be as follows:
- Base ops: 0_0000 ADD, 0_1000 SUB, 0_0001 SLL, 0_0010 SLT, 0_0011 SLTU, 0_0100 XOR, 0_0101 SRL, 0_1101 SRA, 0_0110 OR, 0_0111 AND.
- M ops: 1_x000 MUL, 1_x001 MULH, 1_x010 MULHSU, 1_x011 MULHU, 1_x100 DIV, 1_x101 DIVU, 1_x110 REM, 1_x111 REMU (bit 3 ignored).
- Every other code is reserved and yields Result 0.
REQ-014 An operation is accepted on a rising edge where InValid && InReady; LHS, RHS and Function SHALL be captured at that edge and ignored at all other times.
REQ-015 The state machine SHALL use the states IDLE, MUL, DIV and DONE; InReady = (state == IDLE) && !Reset.
REQ-016 Transitions from IDLE on accept SHALL be:
- base or reserved op: result computed, go to DONE;
- MUL* op: go to MUL;
- DIV/REM op: go to DIV.
REQ-017 Base and reserved ops SHALL raise OutValid in cycle N+1 when accepted in cycle N.
REQ-018 MUL and DIV SHALL each run a WIDTH-cycle iteration counter, one bit per cycle (shift-add multiply, restoring divide on magnitudes), then enter DONE, raising OutValid in cycle N+WIDTH+1 for every M op, including the special cases.
REQ-019 Shift ops SHALL use only RHS[SHAMT_W-1:0]; SRA sign-fills from LHS[WIDTH-1].
REQ-020 SLT/SLTU SHALL produce zero-extended 0 or 1 using signed or unsigned compare respectively.
REQ-021 ADD, SUB and MUL SHALL wrap modulo 2^WIDTH.
REQ-022 MULH, MULHSU and MULHU SHALL return the upper WIDTH bits of the 2*WIDTH product:
- MULH: signed x signed;
- MULHSU: signed LHS x unsigned RHS;
- MULHU: unsigned x unsigned.
REQ-023 DIV and REM SHALL truncate toward zero; the remainder takes the sign of LHS.
REQ-024 Divide by zero: DIV and DIVU SHALL return all ones, and REM and REMU SHALL return LHS.
REQ-025 Signed overflow (LHS = most negative, RHS = -1): DIV SHALL return LHS and REM SHALL return 0.
REQ-026 In DONE, OutValid=1 and Result SHALL hold stable until a cycle with OutReady=1; on that edge go to IDLE and OutValid=0 next cycle.
- Minimum spacing between accepts: 2 cycles for base ops, WIDTH+2 cycles for M ops.
REQ-027 OutReady asserted while OutValid=0 SHALL have no effect; InValid while InReady=0 SHALL be ignored and not queued.
REQ-028 Result SHALL retain its last value while OutValid=0 after the handshake.

Reset
REQ-029 While Reset is high at a rising edge, the next state SHALL be IDLE with OutValid=0, Result=0 and the iteration counter at 0, regardless of any in-flight operation.
REQ-030 InReady SHALL be 0 during any cycle with Reset high and 1 in the first cycle after Reset deasserts.
REQ-031 An operation presented with InValid in a Reset-high cycle SHALL NOT be accepted.

Verification (WIDTH=32)
REQ-032 ADD 5,7 accepted in cycle 0, OutReady=1 -> OutValid=1 and Result=12 in cycle 1, InReady=1 in cycle 2.
REQ-033 SRA 0x80000000,4 -> 0xF8000000; SLT 0xFFFFFFFF,1 -> 1; SLTU 0xFFFFFFFF,1 -> 0; SLL 1,0x21 -> 2.
REQ-034 MUL 0xFFFFFFFF,0xFFFFFFFF -> 1; MULH 0x80000000,0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF,0xFFFFFFFF -> 0xFFFFFFFE; OutValid exactly in cycle 33 after accept in cycle 0.
REQ-035 DIV 7,0 -> 0xFFFFFFFF; REMU 7,0 -> 7; DIV 0x80000000,0xFFFFFFFF -> 0x80000000; REM same -> 0; DIV 0xFFFFFFF9 (-7),2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF.
REQ-036 OutReady held low 10 cycles after OutValid rises -> Result and OutValid stable, InReady=0, and an InValid pulse is not accepted; OutReady=1 -> OutValid=0 and InReady=1 next cycle.
REQ-037 Reset asserted for one cycle at iteration 10 of a DIVU -> OutValid=0 and Result=0 after that edge, InReady=1 the following cycle, and no stale result appears afterwards.
